// File: rtl/sram_access_sequencer.sv
// Phase sequencer for the analog SRAM test macro: precharge, wordline/write-drive, sense, recovery.
// Optional read-back verify of every write is enabled by defining SRAM_SEQ_VERIFY_EN.
module sram_access_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4,
  parameter int T_PRE   = 2,
  parameter int T_WL    = 3,
  parameter int T_SENSE = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic [DATA_W-1:0]      req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_rdata_o,
  output logic                   pc_en_o,
  output logic [(1<<ADDR_W)-1:0] wl_sel_o,
  output logic                   wl_en_o,
  output logic                   wd_en_o,
  output logic [DATA_W-1:0]      wd_data_o,
  output logic                   sa_en_o,
  input  logic [DATA_W-1:0]      sa_data_i,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int NROW  = 1 << ADDR_W;
  localparam int T_MAX = (T_PRE > T_WL) ? ((T_PRE > T_SENSE) ? T_PRE : T_SENSE)
                                        : ((T_WL  > T_SENSE) ? T_WL  : T_SENSE);
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WL, S_SENSE, S_REC} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d, vfy_q, vfy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last, sense_done;

  logic              req_ready_q, req_ready_d, busy_q, busy_d;
  logic              pc_en_q, pc_en_d, wl_en_q, wl_en_d, wd_en_q, wd_en_d, sa_en_q, sa_en_d;
  logic              rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [NROW-1:0]   wl_sel_q, wl_sel_d;
  logic [DATA_W-1:0] wd_data_q, wd_data_d, rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    vfy_d   = vfy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last    = (cnt_q == '0);
    unique case (state_q)
      S_IDLE: if (req_valid_i && req_ready_q) begin
        state_d = S_PRE;
        cnt_d   = CNT_W'(T_PRE - 1);
        we_d    = req_we_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        vfy_d   = 1'b0;
      end
      S_PRE: begin
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          state_d = S_WL;
          cnt_d   = CNT_W'(T_WL - 1);
        end
      end
      S_WL: begin
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          state_d = we_q ? S_REC : S_SENSE;
          cnt_d   = we_q ? '0 : CNT_W'(T_SENSE - 1);
        end
      end
      S_SENSE: begin
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          state_d = S_REC;
          cnt_d   = '0;
        end
      end
      S_REC: begin
        state_d = S_IDLE;
        cnt_d   = '0;
`ifdef SRAM_SEQ_VERIFY_EN
        // Write just finished: read the same row back, keeping wdata for the compare.
        if (we_q) begin
          state_d = S_PRE;
          cnt_d   = CNT_W'(T_PRE - 1);
          we_d    = 1'b0;
          vfy_d   = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next state so every port comes straight off a flop.
  always_comb begin
    sense_done  = (state_q == S_SENSE) && last;
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    pc_en_d     = (state_d == S_PRE);
    wl_en_d     = (state_d == S_WL) || (state_d == S_SENSE);
    wd_en_d     = (state_d == S_WL) && we_d;
    sa_en_d     = (state_d == S_SENSE);
    wl_sel_d    = '0;
    if (wl_en_d) wl_sel_d[addr_d] = 1'b1;
    wd_data_d   = wd_en_d ? wdata_d : '0;
    rsp_valid_d = sense_done && !vfy_q;
    rsp_rdata_d = rsp_valid_d ? sa_data_i : rsp_rdata_q;
`ifdef SRAM_SEQ_VERIFY_EN
    err_d       = err_q | (sense_done && vfy_q && (sa_data_i != wdata_q));
`else
    err_d       = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      vfy_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      pc_en_q     <= 1'b0;
      wl_en_q     <= 1'b0;
      wd_en_q     <= 1'b0;
      sa_en_q     <= 1'b0;
      wl_sel_q    <= '0;
      wd_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      vfy_q       <= vfy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      pc_en_q     <= pc_en_d;
      wl_en_q     <= wl_en_d;
      wd_en_q     <= wd_en_d;
      sa_en_q     <= sa_en_d;
      wl_sel_q    <= wl_sel_d;
      wd_data_q   <= wd_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign busy_o      = busy_q;
  assign pc_en_o     = pc_en_q;
  assign wl_en_o     = wl_en_q;
  assign wd_en_o     = wd_en_q;
  assign sa_en_o     = sa_en_q;
  assign wl_sel_o    = wl_sel_q;
  assign wd_data_o   = wd_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign err_o       = err_q;
endmodule
